// File: rtl/shift_arb_pkg.sv
// Shared types, widths and helpers for the shift arbiter.
// SHIFT_ARB_ROR_EN adds the EXEC2 state used by the rotate-right second pass.
package shift_arb_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

`ifdef SHIFT_ARB_ROR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_EXEC2 = 2'd2,
    S_DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd3
  } state_e;
`endif

  // Operands latched from the winning requester
  typedef struct packed {
    shift_op_e            op;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH-1:0]     data;
    logic                 owner;
  } shift_req_t;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_shifter_r_l_nb.sv
// 32-bit logarithmic right-logical shifter, purely combinational.
module shifter_r_l_nb
  import shift_arb_pkg::*;
(
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout_c
);

  // One conditional power-of-two stage per shift-amount bit
  function automatic logic [WIDTH-1:0] log_shr(input logic [WIDTH-1:0]   x,
                                               input logic [SHAMT_W-1:0] s);
    logic [WIDTH-1:0] v;
    v = x;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (s[i]) v = v >> (1 << i);
    end
    return v;
  endfunction

  assign dout_c = log_shr(din, shamt);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared barrel shifter for two requesters (SRL/SRA/SLL, op 11).
// SHIFT_ARB_ROR_EN: op 11 rotates right in two passes; otherwise op 11 echoes the operand with rsp_err.
module shift_arbiter
  import shift_arb_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ-1:0][1:0]            req_op,
  input  logic [NREQ-1:0][WIDTH-1:0]      req_data,
  input  logic [NREQ-1:0][SHAMT_W-1:0]    req_shamt,
  output logic [NREQ-1:0]                 rsp_valid,
  input  logic [NREQ-1:0]                 rsp_ready,
  output logic [WIDTH-1:0]                rsp_data,
  output logic                            rsp_err,
  output logic                            busy
);

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  shift_req_t         req_q, req_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               win;
  logic               any_req;
  logic [NREQ-1:0]    owner_oh;
  logic [WIDTH-1:0]   lane_a_din;
  logic [SHAMT_W-1:0] lane_a_shamt;
  logic [WIDTH-1:0]   lane_a_dout_c;
  logic [WIDTH-1:0]   lane_b_dout_c;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_err;

  // Winner: rr_ptr breaks ties, otherwise the lone valid requester
  always_comb begin
    any_req = |req_valid;
    win     = 1'b0;
    if (&req_valid) begin
      win = rr_ptr_q;
    end else begin
      win = req_valid[1];
    end
  end

  assign owner_oh = NREQ'(1) << req_q.owner;

  // Data lane operand steering; SLL and the rotate second pass run bit-reversed
  always_comb begin
    lane_a_din   = req_q.data;
    lane_a_shamt = req_q.shamt;
    if (req_q.op == OP_SLL) begin
      lane_a_din = bit_rev(req_q.data);
    end
`ifdef SHIFT_ARB_ROR_EN
    if (state_q == S_EXEC2) begin
      lane_a_din   = bit_rev(req_q.data);
      lane_a_shamt = SHAMT_W'(6'd32 - {1'b0, req_q.shamt});
    end
`endif
  end

  shifter_r_l_nb u_lane_a (
    .din    (lane_a_din),
    .shamt  (lane_a_shamt),
    .dout_c (lane_a_dout_c)
  );

  // Mask lane: ~shr(all-ones, s) gives the sign-fill bits for SRA
  shifter_r_l_nb u_lane_b (
    .din    ({WIDTH{1'b1}}),
    .shamt  (req_q.shamt),
    .dout_c (lane_b_dout_c)
  );

  always_comb begin
    exec_res = lane_a_dout_c;
    exec_err = 1'b0;
    case (req_q.op)
      OP_SRL: exec_res = lane_a_dout_c;
      OP_SRA: exec_res = lane_a_dout_c | (req_q.data[WIDTH-1] ? ~lane_b_dout_c : '0);
      OP_SLL: exec_res = bit_rev(lane_a_dout_c);
      OP_ROR: begin
`ifdef SHIFT_ARB_ROR_EN
        exec_res = lane_a_dout_c;
`else
        exec_res = req_q.data;
        exec_err = 1'b1;
`endif
      end
    endcase
  end

  // Next-state and request/response control
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    req_d       = req_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_ready[win] = rst_n;
          req_d.op       = shift_op_e'(req_op[win]);
          req_d.shamt    = req_shamt[win];
          req_d.data     = req_data[win];
          req_d.owner    = win;
          rr_ptr_d       = ~win;
          state_d        = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d  = exec_res;
        rsp_err_d = exec_err;
`ifdef SHIFT_ARB_ROR_EN
        if (req_q.op == OP_ROR) begin
          state_d = S_EXEC2;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = owner_oh;
        end
`else
        state_d     = S_DONE;
        rsp_valid_d = owner_oh;
`endif
      end
`ifdef SHIFT_ARB_ROR_EN
      S_EXEC2: begin
        result_d    = bit_rev(lane_a_dout_c) | result_q;
        state_d     = S_DONE;
        rsp_valid_d = owner_oh;
      end
`endif
      S_DONE: begin
        if (rsp_ready[req_q.owner]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      req_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_q       <= req_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = result_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized bench for shift_arbiter with a behavioural reference model.
module tb_shift_arbiter;
  import shift_arb_pkg::*;

`ifdef SHIFT_ARB_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  logic                         clk;
  logic                         rst_n;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][1:0]         req_op;
  logic [NREQ-1:0][WIDTH-1:0]   req_data;
  logic [NREQ-1:0][SHAMT_W-1:0] req_shamt;
  logic [NREQ-1:0]              rsp_valid;
  logic [NREQ-1:0]              rsp_ready;
  logic [WIDTH-1:0]             rsp_data;
  logic                         rsp_err;
  logic                         busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit prio;

  shift_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain SV shift operators on the architectural meaning of each op
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'd0:    r = a >> s;
      2'd1:    r = 32'($signed(a) >>> s);
      2'd2:    r = a << s;
      default: r = ROR_EN ? ((a >> s) | (a << (6'd32 - {1'b0, s}))) : a;
    endcase
    return r;
  endfunction

  function automatic bit ref_err(input logic [1:0] op);
    return (op == 2'd3) && !ROR_EN;
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    return (op == 2'd3 && ROR_EN) ? 3 : 2;
  endfunction

  function automatic logic [1:0] onehot(input bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_data"},  rsp_data,       32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  // Present a single request at a negedge and check it is granted that cycle
  task automatic issue(input bit p, input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] s);
    @(negedge clk);
    req_valid    = '0;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_data[p]  = d;
    req_shamt[p] = s;
    #1;
    chk("grant", 32'(req_ready), 32'(onehot(p)));
    prio = ~p;
  endtask

  // Called just after the negedge of the cycle following the accept edge
  task automatic wait_rsp(input bit p, input logic [31:0] exp_d, input bit exp_e,
                          input int exp_lat);
    int lat;
    lat = 1;
    #1;
    while (rsp_valid == '0 && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency",   32'(lat),       32'(exp_lat));
    chk("rsp_valid", 32'(rsp_valid), 32'(onehot(p)));
    chk("rsp_data",  rsp_data,       exp_d);
    chk("rsp_err",   32'(rsp_err),   32'(exp_e));
    rsp_ready = onehot(p);
    @(negedge clk);
    #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy),      32'd0);
    rsp_ready = '0;
  endtask

  task automatic run_op(input bit p, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_d, input bit exp_e,
                        input int exp_lat);
    issue(p, op, d, s);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(p, exp_d, exp_e, exp_lat);
  endtask

  // Cycle-level scoreboard: m_wait -1 idle, >0 executing, 0 holding a result
  task automatic run_model(input int ncyc, input bit contend);
    int          m_wait;
    bit          m_own;
    logic [31:0] m_d;
    bit          m_e;
    bit          w;
    logic [1:0]  exp_rr;
    logic [1:0]  exp_rv;
    m_wait = -1;
    m_own  = 1'b0;
    m_d    = '0;
    m_e    = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        req_op[i]    = 2'($urandom_range(0, 3));
        req_data[i]  = $urandom;
        req_shamt[i] = 5'($urandom_range(0, 31));
      end
      if (contend) begin
        req_valid = 2'b11;
        rsp_ready = 2'b11;
      end else begin
        req_valid = 2'($urandom_range(0, 3));
        rsp_ready = 2'($urandom_range(0, 3));
      end
      if (c >= ncyc - 6) begin
        req_valid = '0;
        rsp_ready = '1;
      end
      #1;
      w      = (&req_valid) ? prio : req_valid[1];
      exp_rr = (m_wait < 0 && |req_valid) ? onehot(w) : 2'b00;
      exp_rv = (m_wait == 0) ? onehot(m_own) : 2'b00;
      chk("m.req_ready", 32'(req_ready), 32'(exp_rr));
      chk("m.rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("m.busy",      32'(busy),      32'(m_wait >= 0));
      if (m_wait == 0) begin
        chk("m.rsp_data", rsp_data,     m_d);
        chk("m.rsp_err",  32'(rsp_err), 32'(m_e));
      end
      if (m_wait < 0) begin
        if (|req_valid) begin
          m_own  = w;
          m_d    = ref_res(req_op[w], req_data[w], req_shamt[w]);
          m_e    = ref_err(req_op[w]);
          m_wait = ref_lat(req_op[w]) - 1;
          prio   = ~w;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rsp_ready[m_own]) begin
        m_wait = -1;
      end
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = '0;
    prio      = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset arriving while an SRL is executing aborts it
    issue(1'b0, 2'd0, 32'hDEAD_BEEF, 5'd3);
    @(negedge clk);
    #1;
    chk("exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    prio  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post_reset.busy",      32'(busy),      32'd0);
      chk("post_reset.rsp_valid", 32'(rsp_valid), 32'd0);
    end

    run_op(1'b0, 2'd1, 32'hF000_0000, 5'd4,  32'hFF00_0000, 1'b0, 2);
    run_op(1'b1, 2'd2, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 2);
    run_op(1'b0, 2'd0, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 2);
    run_op(1'b1, 2'd1, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0, 2);
    run_op(1'b0, 2'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 2);
    run_op(1'b1, 2'd2, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 2);
`ifdef SHIFT_ARB_ROR_EN
    run_op(1'b1, 2'd3, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 3);
    run_op(1'b0, 2'd3, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0, 3);
`else
    run_op(1'b1, 2'd3, 32'h0000_00F1, 5'd4,  32'h0000_00F1, 1'b1, 2);
`endif

    // Owner stalls while the other port requests and asserts rsp_ready
    issue(1'b0, 2'd0, 32'h1234_5678, 5'd8);
    @(negedge clk);
    req_valid    = 2'b10;
    req_op[1]    = 2'd2;
    req_data[1]  = 32'h0000_00A5;
    req_shamt[1] = 5'd4;
    rsp_ready    = 2'b10;
    #1;
    chk("hold.exec_ready", 32'(req_ready), 32'd0);
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("hold.rsp_valid", 32'(rsp_valid), 32'(2'b01));
      chk("hold.rsp_data",  rsp_data,       32'h0012_3456);
      chk("hold.req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("hold.release_valid", 32'(rsp_valid), 32'd0);
    chk("hold.next_grant",    32'(req_ready), 32'(2'b10));
    prio      = 1'b0;
    rsp_ready = '0;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1'b1, 32'h0000_0A50, 1'b0, 2);

    run_model(60, 1'b1);
    run_model(400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
